ms_shift_serializer: RTL
========================

Name: ms_shift_serializer

Overview:
- Parallel-to-serial feeder that sits directly upstream of the 8-stage master-slave shift register.
- Accepts a parallel word over a valid/ready handshake and drives it one bit per clock onto the register's serial input, MSB first.
- After WIDTH bit cycles, the downstream parallel output equals the accepted word, and a one-cycle word_done strobe marks that cycle.
- Optional inter-word gap; optional PRBS idle fill.

Parameters:
- WIDTH, 8, word width and number of bit cycles per word; must match the downstream register depth; legal range 2..32.
- GAP_CYCLES, 0, idle cycles forced between the last bit of one word and the first bit of the next; legal range 0..15.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- r  input  1  asynchronous active-low reset; 0 resets all state immediately.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din holds a valid word.
- din_ready  output  1  block can accept a word this cycle; transfer occurs on a rising edge with din_valid=1 and din_ready=1.
- si  output  1  serial bit to the downstream shift register; registered.
- busy  output  1  a word is being shifted (SHIFT state).
- word_done  output  1  one-cycle pulse; the downstream register now holds the complete word.

Behaviour:
- Reset (r=0, asynchronous):
  - state=IDLE, shift register=0, bit counter=0, gap counter=0.
  - Outputs: si=0, busy=0, word_done=0, din_ready=1.
- States: IDLE, SHIFT, GAP. din_ready is combinational: 1 in IDLE; 1 in SHIFT only on the last bit cycle when GAP_CYCLES=0; 0 otherwise.
- IDLE:
  - si=0 (see Optional Feature).
  - On a transfer: load din into the shift register, bit counter=WIDTH-1, go to SHIFT.
  - si=din[WIDTH-1] from the next cycle.
- SHIFT:
  - Each cycle, si presents the current MSB; the register shifts left with 0 fill; the counter decrements.
  - Bit k of the word appears on si during bit cycle WIDTH-1-k.
- Last bit cycle (counter=0):
  - GAP_CYCLES>0: go to GAP with gap counter=GAP_CYCLES-1.
  - GAP_CYCLES=0 with a concurrent transfer: reload and stay in SHIFT, so there is no bubble and si carries new din[WIDTH-1] next cycle.
  - GAP_CYCLES=0 without a transfer: go to IDLE.
- GAP:
  - si idle value; din_ready=0; counts down.
  - At 0, go to IDLE; a word is first accepted on the following cycle.
- word_done:
  - Registered; asserts the cycle after the last bit cycle, that is, after the downstream register has captured the last bit.
  - Also asserts in back-to-back operation, coincident with the new word's first bit cycle.
- busy=1 exactly during SHIFT cycles.
- Latency: the transfer edge is followed by WIDTH si bit cycles; word_done asserts in the cycle after the last one, i.e. the (WIDTH+1)th cycle after the transfer edge.
- Reset mid-word: the word is abandoned and no word_done is generated. After r releases, the first valid transfer starts a fresh word.
- din_valid with din_ready=0: ignored; the source must hold din. din changes during SHIFT do not affect the word in flight.

Optional Feature:
- Macro: SER_PRBS_IDLE_EN.
- Defined:
  - In IDLE and GAP, si is the MSB of a 7-bit LFSR, polynomial x^7+x^6+1.
  - The LFSR is seeded 7'h7F on reset and advances one step per idle/gap cycle.
  - The LFSR holds its value during SHIFT.
- Undefined: si=0 in IDLE and GAP; no LFSR logic is synthesized.

Test Plan:
- Reset: r=0 mid-operation -> si=0, busy=0, word_done=0, din_ready=1 immediately, without waiting for a clock edge.
- Single word: din=8'hA5, one-cycle valid -> si sequence 1,0,1,0,0,1,0,1; busy high 8 cycles; word_done 1 cycle later; downstream w=8'hA5.
- Back-to-back, GAP_CYCLES=0: din 8'hF0 then 8'h0F, valid held -> 16 contiguous bit cycles; word_done twice, 8 cycles apart; w=8'hF0, then w=8'h0F.
- Gap, GAP_CYCLES=3: two queued words -> exactly 3 cycles with din_ready=0 and si=0 between them; second word starts on the 5th cycle after the first word's last bit cycle (3 gap cycles, then 1 IDLE cycle to accept, then the first bit cycle).
- Reset mid-word: r=0 after bit 4 of 8'hC3 -> no word_done; next word 8'h81 serializes correctly as 1,0,0,0,0,0,0,1.
- SER_PRBS_IDLE_EN defined, idle 10 cycles after reset -> si matches reference LFSR sequence from seed 7'h7F (1,1,1,1,1,1,1,0,...); word 8'h3C is still shifted out unchanged.

Source files
------------

// File: rtl/ms_shift_serializer.sv
// Parallel-to-serial feeder for the master-slave shift register: MSB first, one bit per clock.
// Optional PRBS idle fill on si is enabled by defining SER_PRBS_IDLE_EN.
module ms_shift_serializer #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clock,
  input  logic             r,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             si,
  output logic             busy,
  output logic             word_done,
  output logic [1:0]       state_dbg
);

  // Handshake: a word transfers on a rising clock edge where din_valid and din_ready
  // are both 1; din must be held stable by the source until that edge.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int         CW       = $clog2(WIDTH);
  localparam bit         NO_GAP   = (GAP_CYCLES == 0);
  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic [3:0]       gcnt;
  logic             last_bit;
  logic             xfer;
  logic             idle_bit;

  assign last_bit  = (state == SHIFT) && (cnt == '0);
  assign din_ready = (state == IDLE) || (NO_GAP && last_bit);
  assign xfer      = din_valid && din_ready;
  assign state_dbg = state;

`ifdef SER_PRBS_IDLE_EN
  // x^7+x^6+1 Fibonacci LFSR; frozen while a word is on the wire.
  logic [6:0] lfsr;
  always_ff @(posedge clock or negedge r) begin
    if (!r) begin
      lfsr <= 7'h7F;
    end else if (state != SHIFT) begin
      lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    end
  end
  assign idle_bit = lfsr[6];
`else
  assign idle_bit = 1'b0;
`endif

  // sr holds the bits still to be sent; si already carries the current one.
  always_ff @(posedge clock or negedge r) begin
    if (!r) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      gcnt      <= '0;
      si        <= 1'b0;
      busy      <= 1'b0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            state <= SHIFT;
            busy  <= 1'b1;
            si    <= din[WIDTH-1];
            sr    <= {din[WIDTH-2:0], 1'b0};
            cnt   <= CW'(WIDTH - 1);
          end else begin
            si <= idle_bit;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            si  <= sr[WIDTH-1];
            sr  <= sr << 1;
            cnt <= cnt - 1'b1;
          end else begin
            word_done <= 1'b1;
            if (xfer) begin
              si  <= din[WIDTH-1];
              sr  <= {din[WIDTH-2:0], 1'b0};
              cnt <= CW'(WIDTH - 1);
            end else if (!NO_GAP) begin
              state <= GAP;
              gcnt  <= GAP_LOAD;
              busy  <= 1'b0;
              si    <= idle_bit;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              si    <= idle_bit;
            end
          end
        end
        GAP: begin
          si <= idle_bit;
          if (gcnt == 4'd0) begin
            state <= IDLE;
          end else begin
            gcnt <= gcnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          si    <= idle_bit;
        end
      endcase
    end
  end

endmodule
